// File: rtl/encoder_7to3.sv
// Serialises a 7-bit line vector into one 3-bit code per set bit (code = bit index + 1).
// An empty vector yields the single code 3'b000; a valid/ready handshake paces each code.
module encoder_7to3 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       multi
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] pending_q, pending_d;
  logic [2:0] out_q, out_d;
  logic       out_last_q, out_last_d;
  logic       multi_q, multi_d;
  logic [6:0] remaining;

  function automatic logic [2:0] pick_code(input logic [6:0] vec);
    pick_code = 3'd0;
    if (MSB_FIRST) begin
      for (int k = 0; k < 7; k++) begin
        if (vec[k]) pick_code = 3'(k + 1);
      end
    end else begin
      for (int k = 6; k >= 0; k--) begin
        if (vec[k]) pick_code = 3'(k + 1);
      end
    end
  endfunction

  function automatic logic [2:0] ones(input logic [6:0] vec);
    ones = 3'd0;
    for (int k = 0; k < 7; k++) begin
      ones = ones + 3'(vec[k]);
    end
  endfunction

  // Inverse of the code mapping: code c (1..7) selects line c-1; code 0 selects nothing.
  function automatic logic [6:0] code_mask(input logic [2:0] code);
    code_mask = 7'd0;
    if (code != 3'd0) code_mask[3'(code - 3'd1)] = 1'b1;
  endfunction

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    out_d      = out_q;
    out_last_d = out_last_q;
    multi_d    = multi_q;
    remaining  = pending_q & ~code_mask(out_q);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = EMIT;
          pending_d  = in;
          out_d      = pick_code(in);
          out_last_d = (ones(in) <= 3'd1);
          multi_d    = (ones(in) >= 3'd2);
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d    = IDLE;
            pending_d  = 7'd0;
            out_d      = 3'd0;
            out_last_d = 1'b0;
            multi_d    = 1'b0;
          end else begin
            pending_d  = remaining;
            out_d      = pick_code(remaining);
            out_last_d = (ones(remaining) == 3'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= 7'd0;
      out_q      <= 3'd0;
      out_last_q <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      out_q      <= out_d;
      out_last_q <= out_last_d;
      multi_q    <= multi_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == EMIT);
  assign out       = out_q;
  assign out_last  = out_last_q;
  assign multi     = multi_q;

endmodule

// File: doc/encoder_7to3.md
ENCODER_7TO3 -- requirements
Module: encoder_7to3

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1; 1 = serve highest set bit first, 0 = serve lowest set bit first.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-004 SHALL have port in, input, 7 bits; line vector to encode, bit k maps to code k+1.
REQ-005 SHALL have port in_valid, input, 1 bit; in is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit; block accepts a vector this cycle.
REQ-007 SHALL have port out, output, 3 bits; emitted code, 3'b000 = empty vector, 3'b001..3'b111 = bit 0..6.
REQ-008 SHALL have port out_valid, output, 1 bit; out holds a valid code.
REQ-009 SHALL have port out_ready, input, 1 bit; downstream consumes out this cycle.
REQ-010 SHALL have port out_last, output, 1 bit; current code is the final code of the vector.
REQ-011 SHALL have port multi, output, 1 bit; accepted vector had two or more bits set, held for the whole vector.
REQ-012 The design SHALL use one clock; reset is synchronous and active-high.

Function
REQ-013 The block SHALL serialise each accepted 7-bit vector into one 3-bit code per set bit, each code being the exact inverse of the team's 3-to-7 decoder mapping.
REQ-014 States SHALL be IDLE and EMIT only.
REQ-015 IDLE: in_ready=1, out_valid=0; in_valid=1 -> latch in into pending register, latch multi = (popcount(in) >= 2), go EMIT next cycle.
REQ-016 EMIT: in_ready=0, out_valid=1; in and in_valid ignored.
REQ-017 out SHALL be index+1 of highest (MSB_FIRST=1) or lowest (MSB_FIRST=0) pending bit, registered, valid the cycle out_valid rises.
REQ-018 Latency: vector accepted at edge N -> first code valid after edge N (out_valid=1 in cycle N+1).
REQ-019 out_last SHALL be 1 exactly when pending holds one bit, or when the vector was all-zero.
REQ-020 Handshake: out_valid=1 and out_ready=1 at an edge -> that code consumed, its bit cleared from pending; next code presented the following cycle.
REQ-021 out_valid=1 and out_ready=0: out, out_last, multi SHALL hold stable; no bit cleared.
REQ-022 Consume with out_last=1 -> return to IDLE; in_ready=1 the next cycle (one-cycle bubble between vectors, no overlap).
REQ-023 All-zero vector accepted: emit single code 3'b000 with out_last=1, multi=0.
REQ-024 Full vector 7'b1111111: exactly 7 codes, order 7..1 (MSB_FIRST=1) or 1..7 (MSB_FIRST=0), multi=1 throughout.
REQ-025 multi SHALL clear to 0 on return to IDLE.
REQ-026 in, in_valid in EMIT SHALL have no effect; no vector buffered.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, pending=0, out=3'b000, out_valid=0, out_last=0, multi=0; in_ready=0 while rst=1, 1 the cycle after rst deasserts.
REQ-028 rst asserted mid-EMIT SHALL abandon remaining codes; no further code emitted for that vector.

Verification
REQ-029 MSB_FIRST=1, in=7'b0100101, out_ready=1 -> codes 3'b110, 3'b011, 3'b001 on consecutive cycles, out_last only on 3'b001, multi=1.
REQ-030 in=7'b0000000 -> one code 3'b000, out_last=1, multi=0, in_ready=1 two cycles after accept.
REQ-031 in=7'b0001000, out_ready=0 for 5 cycles then 1 -> out=3'b100, out_last=1, multi=0 stable for all 5 cycles, consumed on 6th.
REQ-032 MSB_FIRST=0, in=7'b1111111, out_ready toggling 1/0 -> codes 1..7 in order, 14 cycles, out_last on 3'b111 only.
REQ-033 in=7'b1010000 accepted, rst=1 after first code consumed -> out_valid=0 next cycle, code 3'b101 never emitted, in_ready=1 after rst release.
REQ-034 in_valid=1 with new vector held during EMIT -> ignored until IDLE, then accepted exactly once.
